// File: rtl/interp_lin_param_pkg.sv
// ---------------------------------------------------------------------------
// interp_pkg
// Shared types and helpers for the linear / zero-order-hold upsampler.
//   state_e    : segment FSM states (EMPTY, PRIME, RUN)
//   acc_ctrl_e : accumulator control issued by the FSM (hold / load / advance)
//   recip_f    : rounded fixed-point reciprocal round(2^frac_w / ratio)
//   sat_f      : clamp a signed value into a signed w-bit range
// ---------------------------------------------------------------------------
package interp_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ACC_HOLD    = 2'd0,
        ACC_LOAD    = 2'd1,
        ACC_ADVANCE = 2'd2
    } acc_ctrl_e;

    // Round-to-nearest reciprocal of the ratio in frac_w fractional bits.
    function automatic int recip_f(input int ratio, input int frac_w);
        longint num;
        num = (64'sd1 <<< frac_w) + longint'(ratio / 32'sd2);
        return int'(num / longint'(ratio));
    endfunction

    // Clamp v into [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [63:0] sat_f(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'sd1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/interp_lin_param_if.sv
// ---------------------------------------------------------------------------
// interp_lin_param_if
// Sample stream bundle of the upsampler.
//   in_data / in_valid / in_ready : low-rate input handshake
//   out_data / out_valid          : high-rate interpolated output
// Modports: master = producer/consumer side, slave = the upsampler.
// ---------------------------------------------------------------------------
interface interp_lin_param_if #(
    parameter int DATA_W = 20
) ();
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/interp_lin_param_step_acc.sv
// ---------------------------------------------------------------------------
// interp_step_acc
// Fixed-point segment accumulator. The step is derived from the registered
// segment end points; the accumulator is loaded with (start << FRAC_W) at each
// segment start so no rounding error carries across segments.
// Ports:
//   clock, reset : high-rate clock, synchronous active-high reset
//   i_ctrl       : ACC_LOAD / ACC_ADVANCE / ACC_HOLD
//   i_start      : registered segment start sample
//   i_target     : registered segment end sample
//   i_load       : sample whose fixed-point value is loaded on ACC_LOAD
//   o_data       : registered, clamped integer part of the accumulator
// ---------------------------------------------------------------------------
module interp_step_acc
    import interp_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int RATIO  = 50,
    parameter int FRAC_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  acc_ctrl_e                i_ctrl,
    input  logic signed [DATA_W-1:0] i_start,
    input  logic signed [DATA_W-1:0] i_target,
    input  logic signed [DATA_W-1:0] i_load,
    output logic signed [DATA_W-1:0] o_data
);
    localparam int ACC_W = DATA_W + FRAC_W + 2;
    localparam int RECIP = recip_f(RATIO, FRAC_W);
    localparam logic signed [ACC_W-1:0] RECIP_S = ACC_W'(RECIP);

    logic signed [DATA_W:0]    w_diff;
    logic signed [ACC_W-1:0]   w_diff_ext;
    logic signed [ACC_W-1:0]   w_step;
    logic signed [ACC_W-1:0]   w_load_acc;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [DATA_W-1:0]  w_out_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_out;

    // Step per output sample from the registered end points.
    always_comb begin
        w_diff     = $signed({i_target[DATA_W-1], i_target}) - $signed({i_start[DATA_W-1], i_start});
        w_diff_ext = ACC_W'(w_diff);
        w_step     = w_diff_ext * RECIP_S;
        w_load_acc = ACC_W'(i_load) <<< FRAC_W;
    end

    // Next accumulator value and its clamped integer part.
    always_comb begin
        w_acc_next = r_acc;
        case (i_ctrl)
            ACC_LOAD:    w_acc_next = w_load_acc;
            ACC_ADVANCE: w_acc_next = r_acc + w_step;
            ACC_HOLD:    w_acc_next = r_acc;
            default:     w_acc_next = r_acc;
        endcase
        // Arithmetic shift floors toward minus infinity.
        w_shifted  = w_acc_next >>> FRAC_W;
        w_out_next = DATA_W'(sat_f(64'(w_shifted), DATA_W));
    end

    // Accumulator and output register; output tracks the accumulator's new value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= {ACC_W{1'b0}};
            r_out <= {DATA_W{1'b0}};
        end else begin
            r_acc <= w_acc_next;
            r_out <= w_out_next;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/interp_lin_param.sv
// ---------------------------------------------------------------------------
// interp_lin_param
// Linear / zero-order-hold upsampler: RATIO output samples per accepted input
// sample. Each segment starts exactly on an input sample. A one-deep buffer
// holds the next target; if none is available at a segment end the block
// repeats the last target (flat segment) and flags an underrun.
// Ports:
//   clock, reset        : high-rate clock, synchronous active-high reset
//   bus (slave)         : in_data/in_valid/in_ready, out_data/out_valid
//   i_mode              : 0 = linear, 1 = hold; sampled at each segment start
//   o_underrun          : one-cycle pulse on a missing sample at segment end
//   o_underrun_sticky   : set by any underrun, cleared only by reset
//   o_underrun_cnt      : saturating underrun count (only when the macro
//                         INTERP_UNDERRUN_CNT_EN is defined)
// ---------------------------------------------------------------------------
module interp_lin_param
    import interp_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int RATIO  = 50,
    parameter int FRAC_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    interp_lin_param_if.slave    bus,
    input  logic                 i_mode,
    output logic                 o_underrun,
    output logic                 o_underrun_sticky
`ifdef INTERP_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          o_underrun_cnt
`endif
);
    localparam int PH_W = $clog2(RATIO);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

    state_e                   r_state;
    state_e                   w_state_next;
    logic signed [DATA_W-1:0] r_start;
    logic signed [DATA_W-1:0] w_start_next;
    logic signed [DATA_W-1:0] r_target;
    logic signed [DATA_W-1:0] w_target_next;
    logic signed [DATA_W-1:0] r_buf;
    logic signed [DATA_W-1:0] w_buf_next;
    logic                     r_buf_valid;
    logic                     w_buf_valid_next;
    logic [PH_W-1:0]          r_ph;
    logic [PH_W-1:0]          w_ph_next;
    logic                     r_mode;
    logic                     w_mode_next;
    logic                     r_out_valid;
    logic                     r_underrun;
    logic                     r_sticky;
    logic                     w_underrun_ev;
    logic                     w_in_ready;
    logic                     w_xfer;
    acc_ctrl_e                w_ctrl;
    logic signed [DATA_W-1:0] w_load;
    logic signed [DATA_W-1:0] w_out_data;

    // Input is accepted in EMPTY/PRIME always, in RUN only while the buffer is free.
    always_comb begin
        if (r_state == ST_RUN) begin
            w_in_ready = ~r_buf_valid;
        end else begin
            w_in_ready = 1'b1;
        end
    end

    assign w_xfer = bus.in_valid & w_in_ready;

    // Next-state, segment bookkeeping and accumulator control.
    always_comb begin
        w_state_next     = r_state;
        w_start_next     = r_start;
        w_target_next    = r_target;
        w_buf_next       = r_buf;
        w_buf_valid_next = r_buf_valid;
        w_ph_next        = r_ph;
        w_mode_next      = r_mode;
        w_ctrl           = ACC_HOLD;
        w_load           = r_target;
        w_underrun_ev    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_start_next = bus.in_data;
                    w_state_next = ST_PRIME;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_PRIME: begin
                if (w_xfer) begin
                    w_target_next = bus.in_data;
                    w_ctrl        = ACC_LOAD;
                    w_load        = r_start;
                    w_ph_next     = {PH_W{1'b0}};
                    w_mode_next   = i_mode;
                    w_state_next  = ST_RUN;
                end else begin
                    w_state_next = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (r_ph == PH_LAST) begin
                    // Segment end: the old target becomes the new start in every case.
                    w_start_next = r_target;
                    w_ctrl       = ACC_LOAD;
                    w_load       = r_target;
                    w_ph_next    = {PH_W{1'b0}};
                    w_mode_next  = i_mode;
                    if (r_buf_valid) begin
                        w_target_next    = r_buf;
                        w_buf_valid_next = 1'b0;
                    end else if (w_xfer) begin
                        // Bypass: a sample arriving exactly now goes straight to target.
                        w_target_next = bus.in_data;
                    end else begin
                        // Target unchanged -> flat segment at the last sample.
                        w_underrun_ev = 1'b1;
                    end
                end else begin
                    w_ph_next = r_ph + PH_W'(1'b1);
                    if (r_mode) begin
                        w_ctrl = ACC_HOLD;
                    end else begin
                        w_ctrl = ACC_ADVANCE;
                    end
                    if (w_xfer) begin
                        w_buf_next       = bus.in_data;
                        w_buf_valid_next = 1'b1;
                    end else begin
                        w_buf_valid_next = r_buf_valid;
                    end
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State, segment and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_start     <= {DATA_W{1'b0}};
            r_target    <= {DATA_W{1'b0}};
            r_buf       <= {DATA_W{1'b0}};
            r_buf_valid <= 1'b0;
            r_ph        <= {PH_W{1'b0}};
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_start     <= w_start_next;
            r_target    <= w_target_next;
            r_buf       <= w_buf_next;
            r_buf_valid <= w_buf_valid_next;
            r_ph        <= w_ph_next;
            r_mode      <= w_mode_next;
            r_out_valid <= (w_state_next == ST_RUN);
            r_underrun  <= w_underrun_ev;
            r_sticky    <= r_sticky | w_underrun_ev;
        end
    end

`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating underrun counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_underrun_cnt <= 16'h0000;
        end else if (w_underrun_ev && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'h0001;
        end else begin
            r_underrun_cnt <= r_underrun_cnt;
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;
`endif

    interp_step_acc #(
        .DATA_W (DATA_W),
        .RATIO  (RATIO),
        .FRAC_W (FRAC_W)
    ) u_step_acc (
        .clock    (clock),
        .reset    (reset),
        .i_ctrl   (w_ctrl),
        .i_start  (r_start),
        .i_target (r_target),
        .i_load   (w_load),
        .o_data   (w_out_data)
    );

    assign bus.in_ready       = w_in_ready;
    assign bus.out_data       = w_out_data;
    assign bus.out_valid      = r_out_valid;
    assign o_underrun         = r_underrun;
    assign o_underrun_sticky  = r_sticky;

endmodule

// File: tb/tb_interp_lin_param.sv
// ---------------------------------------------------------------------------
// tb_interp_lin_param
// Directed bench for interp_lin_param (RATIO=50, FRAC_W=16, RECIP=1311).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_interp_lin_param;

    logic clock;
    logic reset;
    logic mode;
    logic underrun;
    logic underrun_sticky;
`ifdef INTERP_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    interp_lin_param_if #(.DATA_W(20)) bus ();

    interp_lin_param #(
        .DATA_W (20),
        .RATIO  (50),
        .FRAC_W (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .bus               (bus),
        .i_mode            (mode),
        .o_underrun        (underrun),
        .o_underrun_sticky (underrun_sticky)
`ifdef INTERP_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt    (underrun_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int   start;
        int   target;
        logic m;
        int   ph;
        int   exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 20'sd0;
        mode         = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Leaves the bench at the falling edge where ph=0 of the first segment is shown.
    task automatic prime(input int a, input int b, input logic m);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'(a);
        mode         = m;
        cyc();
        bus.in_data  = 20'(b);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int vcnt;

        vecs[0] = '{0,       50000,  1'b0, 0,  0};
        vecs[1] = '{0,       50000,  1'b0, 1,  1000};
        vecs[2] = '{0,       50000,  1'b0, 49, 49010};
        vecs[3] = '{0,       -50000, 1'b0, 1,  -1001};
        vecs[4] = '{0,       -50000, 1'b0, 49, -49011};
        vecs[5] = '{100,     200,    1'b0, 49, 198};
        vecs[6] = '{-1000,   1000,   1'b0, 25, 0};
        vecs[7] = '{10,      20,     1'b1, 49, 10};
        vecs[8] = '{-524288, 524287, 1'b0, 49, 503535};

        reset        = 1'b1;
        mode         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 20'sd0;
        do_reset();

        // Reset state
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_sticky", int'(underrun_sticky), 0);

        // Table-driven ramps: third sample equals target so the next segment starts on it.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            prime(vecs[i].start, vecs[i].target, vecs[i].m);
            bus.in_valid = 1'b1;
            bus.in_data  = 20'(vecs[i].target);
            vcnt = 0;
            for (int p = 0; p < 50; p++) begin
                if (p == vecs[i].ph) chk($sformatf("vec%0d_ph%0d", i, p), int'(bus.out_data), vecs[i].exp);
                if (bus.out_valid) vcnt++;
                cyc();
                if (p == 0) bus.in_valid = 1'b0;
            end
            chk($sformatf("vec%0d_next_ph0", i), int'(bus.out_data), vecs[i].target);
            chk($sformatf("vec%0d_valid_cnt", i), vcnt, 50);
        end

        // Underrun: 100, 200, nothing more -> flat 200 segment, then late 300.
        do_reset();
        prime(100, 200, 1'b0);
        repeat (50) cyc();
        chk("ur_pulse", int'(underrun), 1);
        chk("ur_sticky", int'(underrun_sticky), 1);
        chk("ur_seg2_ph0", int'(bus.out_data), 200);
        cyc();
        chk("ur_pulse_end", int'(underrun), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'sd300;
        cyc();
        bus.in_valid = 1'b0;
        chk("ur_buf_full_ready", int'(bus.in_ready), 0);
        bad = 0;
        for (int p = 2; p < 50; p++) begin
            if (bus.out_data !== 20'sd200) bad++;
            cyc();
        end
        chk("ur_flat_errs", bad, 0);
        chk("ur_seg3_no_pulse", int'(underrun), 0);
        chk("ur_seg3_ph0", int'(bus.out_data), 200);
        chk("ur_sticky_hold", int'(underrun_sticky), 1);
        cyc();
        chk("ur_seg3_ph1", int'(bus.out_data), 202);

        // Bypass: sample offered exactly at ph=49 with an empty buffer.
        do_reset();
        prime(100, 200, 1'b0);
        repeat (49) cyc();
        chk("byp_ready_ph49", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'sd400;
        cyc();
        bus.in_valid = 1'b0;
        chk("byp_no_underrun", int'(underrun), 0);
        chk("byp_sticky_clear", int'(underrun_sticky), 0);
        chk("byp_seg2_ph0", int'(bus.out_data), 200);
        repeat (49) cyc();
        chk("byp_seg2_ph49", int'(bus.out_data), 396);
        cyc();
        chk("byp_seg3_ph0", int'(bus.out_data), 400);
        chk("byp_seg3_underrun", int'(underrun), 1);

        // Hold mode with a mid-segment mode change.
        do_reset();
        prime(10, 20, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'sd30;
        cyc();
        bus.in_valid = 1'b0;
        bad = 0;
        for (int p = 1; p < 50; p++) begin
            if (bus.out_data !== 20'sd10) bad++;
            cyc();
        end
        chk("hold_seg1_errs", bad, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 20'sd40;
        bad = 0;
        for (int p = 0; p < 50; p++) begin
            if (bus.out_data !== 20'sd20) bad++;
            if (p == 25) mode = 1'b0;
            cyc();
            if (p == 0) bus.in_valid = 1'b0;
        end
        chk("hold_seg2_errs", bad, 0);
        chk("lin_seg3_ph0", int'(bus.out_data), 30);
        repeat (49) cyc();
        chk("lin_seg3_ph49", int'(bus.out_data), 39);

        // Reset mid-segment with a buffered sample pending.
        do_reset();
        prime(0, 50000, 1'b0);
        repeat (29) cyc();
        bus.in_valid = 1'b1;
        bus.in_data  = 20'sd777;
        cyc();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_out_data", int'(bus.out_data), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        reset = 1'b0;
        prime(5, 6, 1'b0);
        chk("mid_rst_buf_cleared", int'(bus.in_ready), 1);
        chk("mid_rst_restart_ph0", int'(bus.out_data), 5);

`ifdef INTERP_UNDERRUN_CNT_EN
        // Three forced underruns.
        do_reset();
        chk("cnt_rst", int'(underrun_cnt), 0);
        prime(1, 2, 1'b0);
        repeat (150) cyc();
        chk("cnt_three", int'(underrun_cnt), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
